// File: rtl/bp_jtag_readback.sv
// bp_jtag_readback: return path of the backplane JTAG reconfiguration channel.
// Samples TDO on each synchronised TCK rise and packs the bits LSB-first into bytes.
// Completed bytes go into a circular FIFO that slow control drains over its own RBCP page.
module bp_jtag_readback #(
    parameter logic [19:0] PAGE       = 20'd3,
    parameter int          DEPTH_LOG2 = 9
) (
    input  logic        CLK_133m,
    input  logic        RST,
    input  logic        JTAG_TCK,
    input  logic        JTAG_TDO,
    input  logic        RBCP_ACT,
    input  logic [31:0] RBCP_ADDR,
    input  logic        RBCP_WE,
    input  logic [7:0]  RBCP_WD,
    input  logic        RBCP_RE,
    output logic [7:0]  RBCP_RD,
    output logic        RBCP_ACK
);
    localparam int                  DEPTH    = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    // RBCP pipeline registers
    logic [31:0] addr_p0;
    logic [7:0]  wd_p0, wd_p1, wd_p2, off_p1, off_p2;
    logic        we_p0, re_p0, we_p1, re_p1, we_p2, re_p2;

    // TCK/TDO capture
    logic       tck_s1, tck_s2, tck_s3, tdo_s1, tdo_s2;
    logic       enable, rise, cap, byte_done;
    logic [2:0] bitcnt;
    logic [7:0] shreg, byte_new;

    // FIFO
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  full, empty, overflow, underflow;

    // Stage-3 access decode
    logic       data_rd, ctrl_wr, flush, clr_flags, pop, push;
    logic [7:0] rd_mux;

    // Stage 1: register the raw bus, strobes qualified by RBCP_ACT
    always_ff @(posedge CLK_133m or posedge RST) begin
        if (RST) begin
            addr_p0 <= '0;
            wd_p0   <= '0;
            we_p0   <= 1'b0;
            re_p0   <= 1'b0;
        end else begin
            addr_p0 <= RBCP_ADDR;
            wd_p0   <= RBCP_WD;
            we_p0   <= RBCP_WE & RBCP_ACT;
            re_p0   <= RBCP_RE & RBCP_ACT;
        end
    end

    // Stage 2: page decode; a second register keeps the decode off the FIFO read path
    always_ff @(posedge CLK_133m or posedge RST) begin
        if (RST) begin
            off_p1 <= '0;
            wd_p1  <= '0;
            we_p1  <= 1'b0;
            re_p1  <= 1'b0;
            off_p2 <= '0;
            wd_p2  <= '0;
            we_p2  <= 1'b0;
            re_p2  <= 1'b0;
        end else begin
            off_p1 <= addr_p0[7:0];
            wd_p1  <= wd_p0;
            we_p1  <= we_p0 && (addr_p0[31:12] == PAGE);
            re_p1  <= re_p0 && (addr_p0[31:12] == PAGE);
            off_p2 <= off_p1;
            wd_p2  <= wd_p1;
            we_p2  <= we_p1;
            re_p2  <= re_p1;
        end
    end

    assign rise      = tck_s2 & ~tck_s3;
    assign cap       = rise & enable;
    assign byte_done = cap && (bitcnt == 3'd7);
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign data_rd   = re_p2 && (off_p2 == 8'h00);
    assign ctrl_wr   = we_p2 && (off_p2 == 8'h10);
    assign flush     = ctrl_wr & wd_p2[1];
    assign clr_flags = ctrl_wr & wd_p2[2];
    assign pop       = data_rd & ~empty;
    // A full FIFO still accepts the byte when a pop frees a slot in the same cycle
    assign push      = byte_done & ~flush & (~full | pop);

    // Current byte with the incoming bit merged in at position bitcnt
    always_comb begin
        byte_new         = shreg;
        byte_new[bitcnt] = tdo_s2;
    end

    // Stage 3: read data selection, sampled before this cycle's updates
    always_comb begin
        rd_mux = 8'd0;
        case (off_p2)
            8'h00:   rd_mux = empty ? 8'd0 : mem[rd_ptr];
            8'h01:   rd_mux = {1'b0, bitcnt, underflow, overflow, full, empty};
            8'h02:   rd_mux = 8'(count);
            8'h03:   rd_mux = 8'(count >> 8);
            8'h10:   rd_mux = {7'd0, enable};
            default: rd_mux = 8'd0;
        endcase
    end

    // Stage 3: registered acknowledge and read data
    always_ff @(posedge CLK_133m or posedge RST) begin
        if (RST) begin
            RBCP_ACK <= 1'b0;
            RBCP_RD  <= 8'd0;
        end else begin
            RBCP_ACK <= re_p2 | we_p2;
            RBCP_RD  <= re_p2 ? rd_mux : 8'd0;
        end
    end

    // Control register and sticky flags; a set in the same cycle beats a clear
    always_ff @(posedge CLK_133m or posedge RST) begin
        if (RST) begin
            enable    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ctrl_wr)
                enable <= wd_p2[0];
            if (byte_done && !flush && full && !pop)
                overflow <= 1'b1;
            else if (clr_flags)
                overflow <= 1'b0;
            if (data_rd && empty)
                underflow <= 1'b1;
            else if (clr_flags)
                underflow <= 1'b0;
        end
    end

    // TCK/TDO synchronisers of equal depth, then bit packing; capture uses the pre-write enable
    always_ff @(posedge CLK_133m or posedge RST) begin
        if (RST) begin
            tck_s1 <= 1'b0;
            tck_s2 <= 1'b0;
            tck_s3 <= 1'b0;
            tdo_s1 <= 1'b0;
            tdo_s2 <= 1'b0;
            bitcnt <= 3'd0;
            shreg  <= 8'd0;
        end else begin
            tck_s1 <= JTAG_TCK;
            tck_s2 <= tck_s1;
            tck_s3 <= tck_s2;
            tdo_s1 <= JTAG_TDO;
            tdo_s2 <= tdo_s1;
            if (flush) begin
                bitcnt <= 3'd0;
            end else if (cap) begin
                shreg  <= byte_new;
                bitcnt <= bitcnt + 3'd1;
            end
        end
    end

    // FIFO pointers and occupancy; flush wins over any push or pop
    always_ff @(posedge CLK_133m or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge CLK_133m) begin
        if (push)
            mem[wr_ptr] <= byte_new;
    end

endmodule

// File: tb/tb_bp_jtag_readback.sv
// tb_bp_jtag_readback: directed bench with a scoreboard of expected RBCP acknowledges.
`timescale 1ns/1ps
module tb_bp_jtag_readback;
    localparam logic [19:0] PAGE = 20'd3;
    localparam logic [19:0] OTHER = 20'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tck, tdo, act, we, re, ack;
    logic [31:0] addr;
    logic [7:0]  wd, rd;

    typedef struct {
        logic [7:0] d;
        int         cyc;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   ack_cnt = 0;

    bp_jtag_readback #(.PAGE(PAGE), .DEPTH_LOG2(9)) dut (
        .CLK_133m (clk),
        .RST      (rst),
        .JTAG_TCK (tck),
        .JTAG_TDO (tdo),
        .RBCP_ACT (act),
        .RBCP_ADDR(addr),
        .RBCP_WE  (we),
        .RBCP_WD  (wd),
        .RBCP_RE  (re),
        .RBCP_RD  (rd),
        .RBCP_ACK (ack)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every acknowledge is matched against the oldest expected response
    always @(negedge clk) begin
        exp_t e;
        if (ack) begin
            ack_cnt++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ack: got rd=%02h, required no ack", rd);
            end else begin
                e = sb.pop_front();
                if (rd !== e.d || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL %s: got rd=%02h at cycle %0d, required %02h at cycle %0d",
                             e.nm, rd, cyc, e.d, e.cyc);
                end
            end
        end else if (rd !== 8'd0) begin
            tests++;
            fails++;
            $display("FAIL rd_idle: got rd=%02h with ack low, required 00", rd);
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout_%s: got no ack, required rd=%02h", sb[0].nm, sb[0].d);
            sb.delete();
        end
    endtask

    task automatic bus(input logic [19:0] pg, input logic [7:0] off, input logic wr,
                       input logic [7:0] wdata, input logic [7:0] expd, input string nm);
        exp_t e;
        @(negedge clk);
        if (pg == PAGE) begin
            e.d   = wr ? 8'd0 : expd;
            e.cyc = cyc + 4;
            e.nm  = nm;
            sb.push_back(e);
        end
        act  = 1'b1;
        addr = {pg, 4'h0, off};
        we   = wr;
        re   = ~wr;
        wd   = wdata;
        @(negedge clk);
        act = 1'b0;
        we  = 1'b0;
        re  = 1'b0;
        drain();
    endtask

    task automatic rd_chk(input logic [7:0] off, input logic [7:0] expd, input string nm);
        bus(PAGE, off, 1'b0, 8'd0, expd, nm);
    endtask

    task automatic wr_reg(input logic [7:0] off, input logic [7:0] wdata);
        bus(PAGE, off, 1'b1, wdata, 8'd0, "write");
    endtask

    task automatic tck_bit(input logic b, input int h);
        @(negedge clk);
        tdo = b;
        tck = 1'b0;
        repeat (h) @(negedge clk);
        tck = 1'b1;
        repeat (h) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int h);
        for (int i = 0; i < 8; i++) tck_bit(b[i], h);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq;
        exp_t       e;
        int         a0;
        rst = 1'b1; tck = 1'b0; tdo = 1'b0; act = 1'b0;
        we = 1'b0; re = 1'b0; addr = '0; wd = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (ack !== 1'b0 || rd !== 8'd0) begin
            fails++;
            $display("FAIL reset_outputs: got ack=%b rd=%02h, required 0 00", ack, rd);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state, underflow, unmapped offsets
        rd_chk(8'h01, 8'h01, "status_reset");
        rd_chk(8'h10, 8'h00, "ctrl_reset");
        rd_chk(8'h02, 8'h00, "count_reset");
        rd_chk(8'h20, 8'h00, "unmapped_rd");
        wr_reg(8'h20, 8'hFF);
        rd_chk(8'h00, 8'h00, "data_empty");
        rd_chk(8'h01, 8'h09, "status_underflow");
        wr_reg(8'h10, 8'h05);
        rd_chk(8'h01, 8'h01, "status_clr_uf");
        rd_chk(8'h10, 8'h01, "ctrl_enable");

        // One byte, TCK = CLK/8, TDO 1,0,1,1,0,0,1,0 -> 0x4D
        seq = 8'h4D;
        send_byte(seq, 4);
        rd_chk(8'h02, 8'h01, "count_one");
        rd_chk(8'h00, 8'h4D, "data_4d");
        rd_chk(8'h02, 8'h00, "count_zero");

        // Overflow: one byte more than the FIFO holds, then drain
        for (int i = 0; i < 513; i++) send_byte(8'hA5, 2);
        rd_chk(8'h01, 8'h06, "status_full_ovf");
        rd_chk(8'h02, 8'h00, "count_l_full");
        rd_chk(8'h03, 8'h02, "count_h_full");
        for (int i = 0; i < 512; i++) rd_chk(8'h00, 8'hA5, "drain_a5");
        rd_chk(8'h01, 8'h05, "status_empty_ovf");
        wr_reg(8'h10, 8'h05);
        rd_chk(8'h01, 8'h01, "status_ovf_clr");
        rd_chk(8'h10, 8'h01, "ctrl_kept");

        // Flush: discards FIFO contents and a 3-bit partial byte
        send_byte(8'h11, 2);
        for (int i = 0; i < 3; i++) tck_bit(1'b1, 2);
        repeat (4) @(negedge clk);
        rd_chk(8'h01, 8'h30, "status_partial");
        wr_reg(8'h10, 8'h03);
        rd_chk(8'h01, 8'h01, "status_flushed");
        send_byte(8'h3C, 2);
        rd_chk(8'h00, 8'h3C, "clean_byte");

        // Count 5, then a pop in the same cycle the next byte is pushed
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 2);
        seq = 8'h66;
        for (int i = 0; i < 7; i++) tck_bit(seq[i], 2);
        @(negedge clk);
        tdo = seq[7];
        tck = 1'b0;
        repeat (4) @(negedge clk);
        e.d = 8'h01; e.cyc = cyc + 4; e.nm = "pop_with_push";
        sb.push_back(e);
        act = 1'b1; addr = {PAGE, 12'h000}; re = 1'b1;
        @(negedge clk);
        act = 1'b0; re = 1'b0; tck = 1'b1;
        repeat (4) @(negedge clk);
        drain();
        rd_chk(8'h02, 8'h05, "count_stays_5");

        // Out-of-page accesses: no ack, no side effects
        a0 = ack_cnt;
        bus(OTHER, 8'h10, 1'b1, 8'h02, 8'h00, "oop_wr");
        bus(OTHER, 8'h00, 1'b0, 8'h00, 8'h00, "oop_rd");
        repeat (6) @(negedge clk);
        tests++;
        if (ack_cnt != a0) begin
            fails++;
            $display("FAIL oop_no_ack: got %0d acks, required 0", ack_cnt - a0);
        end
        rd_chk(8'h01, 8'h00, "status_after_oop");
        rd_chk(8'h10, 8'h01, "ctrl_after_oop");
        rd_chk(8'h00, 8'h02, "order_02");
        rd_chk(8'h00, 8'h03, "order_03");
        rd_chk(8'h00, 8'h04, "order_04");
        rd_chk(8'h00, 8'h05, "order_05");
        rd_chk(8'h00, 8'h66, "order_66");
        rd_chk(8'h01, 8'h01, "status_drained");

        // Reset mid-byte with a read in flight
        send_byte(8'h77, 2);
        for (int i = 0; i < 3; i++) tck_bit(1'b1, 2);
        a0 = ack_cnt;
        @(negedge clk);
        act = 1'b1; addr = {PAGE, 12'h001}; re = 1'b1;
        @(negedge clk);
        act = 1'b0; re = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (ack_cnt != a0) begin
            fails++;
            $display("FAIL ack_cancel: got %0d acks, required 0", ack_cnt - a0);
        end
        rd_chk(8'h01, 8'h01, "status_after_rst");
        rd_chk(8'h10, 8'h00, "ctrl_after_rst");
        rd_chk(8'h02, 8'h00, "count_after_rst");
        send_byte(8'hFF, 2);
        rd_chk(8'h01, 8'h01, "disabled_ignores");

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bp_jtag_readback.md
Name: bp_jtag_readback

Overview:
- Return path of the backplane JTAG reconfiguration channel.
- Samples JTAG_TDO on each rising edge of the JTAG_TCK generated by the JTAG player and packs the bits LSB-first into bytes.
- Buffers the bytes in an internal FIFO so slow control can read them back over RBCP.
- Occupies its own RBCP page, next to the write-side reconfiguration page.

Parameters:
- PAGE, 20'd3: RBCP page. The block responds only when RBCP_ADDR[31:12] == PAGE.
- DEPTH_LOG2, 9: FIFO depth is 2**DEPTH_LOG2 bytes (512 by default).

Ports:
- CLK_133m  in  1  system clock; all logic is in this single clock domain
- RST  in  1  asynchronous, active-high reset
- JTAG_TCK  in  1  JTAG clock from the player; asynchronous to CLK_133m, at most CLK_133m/4
- JTAG_TDO  in  1  target data out
- RBCP_ACT  in  1  RBCP active (unused other than for qualification)
- RBCP_ADDR  in  32  RBCP address
- RBCP_WE  in  1  write strobe, one cycle
- RBCP_WD  in  8  write data
- RBCP_RE  in  1  read strobe, one cycle
- RBCP_RD  out  8  read data; 8'd0 whenever RBCP_ACK is low
- RBCP_ACK  out  1  acknowledge, one-cycle pulse

Behaviour:
- Reset (asynchronous, active-high): every register clears.
  - RBCP_ACK=0, RBCP_RD=0.
  - FIFO empty, bit counter 0, enable=0, overflow=0.
- RBCP pipeline:
  - Stage 1 registers ADDR/WE/WD/RE.
  - Stage 2 decodes chip select (ADDR[31:12]==PAGE) and latches ADDR[7:0] and WD.
  - Stage 3 performs the access. RBCP_ACK and RBCP_RD are registered outputs driven in stage 3.
  - A strobe sampled at edge N produces ACK high for exactly the cycle after edge N+3.
  - An access outside the page gives no ACK and no side effects.
  - Any address inside the page acks. Unmapped reads return 8'd0; unmapped writes are ignored.
- Register map (offset = ADDR[7:0]):
  - 0x00 R DATA: returns the FIFO head and pops it in the ack cycle. If the FIFO is empty it returns 8'd0, does not pop, and sets the sticky underflow bit.
  - 0x01 R STATUS: {1'b0, bitcnt[2:0], underflow, overflow, full, empty}.
  - 0x02 R COUNT_L: occupancy[7:0].
  - 0x03 R COUNT_H: occupancy[DEPTH_LOG2:8], zero-extended.
  - 0x10 R/W CTRL: bit0 = enable (stored, reads back).
    - bit1 = flush (self-clearing): empties the FIFO and zeroes the bit counter.
    - bit2 = clear sticky flags (self-clearing): clears overflow and underflow.
    - CTRL reads return {7'd0, enable}.
- TCK capture:
  - JTAG_TCK and JTAG_TDO each pass through 2-flop synchronisers with identical depth.
  - A third TCK flop drives rise detection: sync2 & ~sync3.
  - On a rise with enable=1, the synchronised TDO is shifted into bit position bitcnt, bitcnt increments, and bit 0 is the first sampled bit.
  - With enable=0, rises are ignored and bitcnt holds.
- Packing:
  - When bitcnt wraps 7→0, the completed byte is pushed in the same cycle.
  - If the FIFO is full, the byte is dropped and overflow is set; the contents are unchanged.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit pointers (wrap-around) and a (DEPTH_LOG2+1)-bit occupancy count.
  - full = (count == 2**DEPTH_LOG2); empty = (count == 0).
- Simultaneous events:
  - Push and pop in the same cycle both succeed and count is unchanged. A push into a full FIFO with a simultaneous pop succeeds.
  - A flush coinciding with a push: the flush wins and the byte is discarded.
  - A write that clears enable in the same cycle as a TCK rise: the rise is still captured.
  - A partial byte is kept across enable=0 and completes when capture resumes.
- Reset mid-operation: the partial byte and all FIFO contents are lost, and any ACK in flight is cancelled.

Test Plan:
- Reset, then read 0x01 → ACK 4 cycles after RE, RD=0x01 (empty). Read 0x00 → RD=0x00, then 0x01 reads 0x09 (underflow+empty).
- Write 0x10=0x01, then drive 8 TCK periods (TCK=CLK/8) with TDO sequence 1,0,1,1,0,0,1,0 → COUNT_L=1; read 0x00 → 0x4D; COUNT_L=0.
- Enable and drive 2**DEPTH_LOG2+1 bytes of 0xA5 → 0x01 reads 0x06 (overflow+full). Drain 512 reads, all 0xA5 → empty. Write 0x10=0x05 → overflow cleared, enable kept.
- Drive 3 bits, then write 0x10=0x03 (flush) → STATUS bitcnt=0, empty. Next 8 bits form a clean byte.
- Hold FIFO at count=5 and issue a DATA read in the same cycle a byte completes → COUNT stays 5 and the popped value is the oldest byte.
- Access with ADDR[31:12]≠PAGE → no ACK, RD stays 0, no state change. Assert RST mid-byte → all status reads return reset values.
